// File: rtl/ula_ctrl_pkg.sv
// Shared widths and FSM state type for the ULA request arbiter.
package ula_ctrl_pkg;
  localparam int A_W   = 16;
  localparam int SEL_W = 2;
  localparam int OP_W  = 2;
  localparam int D_W   = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} ula_arb_state_t;
endpackage

// File: rtl/ula_req_arbiter_if.sv
// Requester-side bus (many masters, one arbiter) and ULA-side bus (arbiter to ULA slave).
interface ula_req_arbiter_if #(
  parameter int NREQ = 4
);
  import ula_ctrl_pkg::*;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*A_W-1:0]   req_A;
  logic [NREQ*SEL_W-1:0] req_reg_sel;
  logic [NREQ*OP_W-1:0]  req_instru;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [D_W-1:0]        rsp_data;
  logic                  rsp_err;

  modport master (
    output req_valid, req_A, req_reg_sel, req_instru,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_A, req_reg_sel, req_instru,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

interface ula_bus_if;
  import ula_ctrl_pkg::*;

  logic [A_W-1:0]   ula_A;
  logic [SEL_W-1:0] ula_reg_sel;
  logic [OP_W-1:0]  ula_instru;
  logic             ula_valid;
  logic [D_W-1:0]   ula_data;
  logic             ula_valid_out;

  modport master (
    output ula_A, ula_reg_sel, ula_instru, ula_valid,
    input  ula_data, ula_valid_out
  );

  modport slave (
    input  ula_A, ula_reg_sel, ula_instru, ula_valid,
    output ula_data, ula_valid_out
  );
endinterface

// File: rtl/ula_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod NREQ.
module ula_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any && req[(int'(ptr) + k) % NREQ]) begin
        any = 1'b1;
        grant[(int'(ptr) + k) % NREQ] = 1'b1;
        idx = IW'((int'(ptr) + k) % NREQ);
      end
    end
  end
endmodule

// File: rtl/ula_req_arbiter.sv
// Round-robin arbiter sharing one ULA between NREQ requesters, one transaction in flight,
// with a WAIT timeout and a saturating counter of unsolicited ULA completions.
module ula_req_arbiter
  import ula_ctrl_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_ula,
  input  logic             rst,
  ula_req_arbiter_if.slave req_bus,
  ula_bus_if.master        ula_bus,
  output logic             busy,
  output logic [7:0]       stray_cnt
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TIMEOUT);

  ula_arb_state_t   state, state_nxt;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    gnt_idx;
  logic [IW-1:0]    pick_idx;
  logic [NREQ-1:0]  pick_gnt;
  logic             pick_any;
  logic [WW-1:0]    wcnt;
  logic             timeout_hit;
  logic [A_W-1:0]   a_q;
  logic [SEL_W-1:0] sel_q;
  logic [OP_W-1:0]  ins_q;
  logic [D_W-1:0]   res_q;
  logic             err_q;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  ula_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req  (req_bus.req_valid),
    .ptr  (rr_ptr),
    .grant(pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign timeout_hit = (wcnt == WW'(TIMEOUT - 1));

  always_ff @(posedge clk_ula) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      wcnt      <= '0;
      stray_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ISSUE)
        wcnt <= '0;
      else if (state == WAIT && !timeout_hit)
        wcnt <= wcnt + 1'b1;
      if (state == RESP)
        rr_ptr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      if ((state == IDLE || state == RESP) && ula_bus.ula_valid_out)
        stray_cnt <= sat_inc(stray_cnt);
    end
  end

  // Operand and result latches carry no reset: every consumer is gated by state.
  always_ff @(posedge clk_ula) begin
    if (state == IDLE && pick_any) begin
      gnt_idx <= pick_idx;
      a_q     <= req_bus.req_A[A_W*pick_idx +: A_W];
      sel_q   <= req_bus.req_reg_sel[SEL_W*pick_idx +: SEL_W];
      ins_q   <= req_bus.req_instru[OP_W*pick_idx +: OP_W];
    end
    if ((state == ISSUE || state == WAIT) && ula_bus.ula_valid_out) begin
      res_q <= ula_bus.ula_data;
      err_q <= 1'b0;
    end else if (state == WAIT && timeout_hit) begin
      res_q <= '0;
      err_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt           = state;
    req_bus.req_ready   = '0;
    req_bus.rsp_valid   = '0;
    req_bus.rsp_data    = '0;
    req_bus.rsp_err     = 1'b0;
    ula_bus.ula_A       = '0;
    ula_bus.ula_reg_sel = '0;
    ula_bus.ula_instru  = '0;
    ula_bus.ula_valid   = 1'b0;
    busy                = 1'b0;

    unique case (state)
      IDLE:    if (pick_any) state_nxt = ISSUE;
      ISSUE:   state_nxt = ula_bus.ula_valid_out ? RESP : WAIT;
      WAIT:    if (ula_bus.ula_valid_out || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Outputs are held quiet during reset so no accept or response leaks out.
    if (!rst) begin
      busy = (state != IDLE);
      case (state)
        IDLE: req_bus.req_ready = pick_gnt;
        ISSUE: begin
          ula_bus.ula_valid   = 1'b1;
          ula_bus.ula_A       = a_q;
          ula_bus.ula_reg_sel = sel_q;
          ula_bus.ula_instru  = ins_q;
        end
        WAIT: begin
          ula_bus.ula_A       = a_q;
          ula_bus.ula_reg_sel = sel_q;
          ula_bus.ula_instru  = ins_q;
        end
        RESP: begin
          req_bus.rsp_valid[gnt_idx] = 1'b1;
          req_bus.rsp_data           = res_q;
          req_bus.rsp_err            = err_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ula_req_arbiter.sv
// Randomized bench for ula_req_arbiter against a transaction-timing reference model.
module tb_ula_req_arbiter;
  import ula_ctrl_pkg::*;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 8;
  localparam int SILENT  = 1000;

  logic       clk_ula = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [7:0] stray_cnt;

  ula_req_arbiter_if #(.NREQ(NREQ)) req_bus ();
  ula_bus_if ula_bus ();

  ula_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk_ula  (clk_ula),
    .rst      (rst),
    .req_bus  (req_bus),
    .ula_bus  (ula_bus),
    .busy     (busy),
    .stray_cnt(stray_cnt)
  );

  always #5 clk_ula = ~clk_ula;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // requester population
  bit              pend [NREQ];
  logic [15:0]     op_a [NREQ];
  logic [1:0]      op_sel [NREQ];
  logic [1:0]      op_ins [NREQ];
  bit [NREQ-1:0]   req_mask = '0;
  int              arrive_pct = 0;
  int              drop_pct = 0;

  // ULA behaviour for the next accepted transaction
  bit              rand_lat = 1'b0;
  int              next_lat = 0;
  logic [31:0]     next_data = '0;

  // reference model: one transaction described by its accept cycle and response cycle
  bit              m_active = 1'b0;
  int              m_t, m_rsp, m_g, m_lat;
  int              rr = 0;
  int              m_stray = 0;
  logic [15:0]     m_a;
  logic [1:0]      m_sel, m_ins;
  logic [31:0]     m_data;
  bit              m_err;

  // observations
  int              grant_log[$];
  int              last_uv = -1;
  int              last_rsp_delta = -1;
  logic [31:0]     last_rsp_data = '0;
  logic            last_rsp_err = 1'b0;
  int              rsp_count = 0;

  function automatic int pick_ref();
    for (int k = 0; k < NREQ; k++)
      if (pend[(rr + k) % NREQ]) return (rr + k) % NREQ;
    return -1;
  endfunction

  function automatic bit any_pend();
    for (int i = 0; i < NREQ; i++)
      if (pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic cycle(input bit do_rst, input bit stray);
    bit              inwin, pulse;
    int              g;
    logic [NREQ-1:0] exp_ready, exp_rsp;
    for (int i = 0; i < NREQ; i++) begin
      req_bus.req_valid[i]           = pend[i];
      req_bus.req_A[16*i +: 16]      = op_a[i];
      req_bus.req_reg_sel[2*i +: 2]  = op_sel[i];
      req_bus.req_instru[2*i +: 2]   = op_ins[i];
    end
    rst = do_rst;
    inwin = m_active && (cyc < m_rsp);
    pulse = 1'b0;
    ula_bus.ula_data = $urandom();
    if (m_active && m_lat <= TIMEOUT && cyc == m_t + 1 + m_lat) begin
      pulse = 1'b1;
      ula_bus.ula_data = m_data;
    end else if (!inwin && stray) begin
      pulse = 1'b1;
    end
    ula_bus.ula_valid_out = pulse;
    g = pick_ref();
    #1;
    if (!do_rst) begin
      exp_ready = '0;
      if (!m_active && g >= 0) exp_ready[g] = 1'b1;
      exp_rsp = '0;
      if (m_active && cyc == m_rsp) exp_rsp[m_g] = 1'b1;
      check("req_ready", req_bus.req_ready, exp_ready);
      check("busy", busy, m_active);
      check("ula_valid", ula_bus.ula_valid, m_active && cyc == m_t + 1);
      check("ula_A", ula_bus.ula_A, inwin ? m_a : 16'h0);
      check("ula_reg_sel", ula_bus.ula_reg_sel, inwin ? m_sel : 2'h0);
      check("ula_instru", ula_bus.ula_instru, inwin ? m_ins : 2'h0);
      check("rsp_valid", req_bus.rsp_valid, exp_rsp);
      check("rsp_data", req_bus.rsp_data, (exp_rsp != 0) ? m_data : 32'h0);
      check("rsp_err", req_bus.rsp_err, (exp_rsp != 0) ? m_err : 1'b0);
      check("stray_cnt", stray_cnt, m_stray);
      for (int i = 0; i < NREQ; i++)
        if (req_bus.req_ready[i]) grant_log.push_back(i);
      if (ula_bus.ula_valid) last_uv = cyc;
      if (req_bus.rsp_valid != 0) begin
        rsp_count++;
        last_rsp_delta = cyc - last_uv;
        last_rsp_data  = req_bus.rsp_data;
        last_rsp_err   = req_bus.rsp_err;
      end
    end

    if (do_rst) begin
      m_active = 1'b0;
      rr = 0;
      m_stray = 0;
    end else begin
      if (pulse && !inwin) m_stray = (m_stray < 255) ? m_stray + 1 : 255;
      if (m_active) begin
        if (cyc == m_rsp) begin
          m_active = 1'b0;
          rr = (m_g + 1) % NREQ;
        end
      end else if (g >= 0) begin
        m_active = 1'b1;
        m_t   = cyc;
        m_g   = g;
        m_a   = op_a[g];
        m_sel = op_sel[g];
        m_ins = op_ins[g];
        pend[g] = 1'b0;
        m_lat = rand_lat ? int'($urandom_range(0, TIMEOUT + 2)) : next_lat;
        m_err = (m_lat > TIMEOUT);
        m_rsp = cyc + 2 + (m_err ? TIMEOUT : m_lat);
        m_data = m_err ? 32'h0 : (rand_lat ? 32'($urandom()) : next_data);
      end
    end

    for (int i = 0; i < NREQ; i++) begin
      if (!pend[i] && req_mask[i] && $urandom_range(0, 99) < arrive_pct) begin
        pend[i]   = 1'b1;
        op_a[i]   = 16'($urandom());
        op_sel[i] = 2'($urandom());
        op_ins[i] = 2'($urandom());
      end else if (pend[i] && $urandom_range(0, 99) < drop_pct) begin
        pend[i] = 1'b0;
      end
    end
    @(negedge clk_ula);
    cyc++;
  endtask

  task automatic run(input int n, input bit stray);
    for (int k = 0; k < n; k++) cycle(1'b0, stray);
  endtask

  task automatic wait_idle(input int max);
    int k = 0;
    while ((m_active || any_pend()) && k < max) begin
      cycle(1'b0, 1'b0);
      k++;
    end
    check("wait_bound", m_active || any_pend(), 1'b0);
  endtask

  task automatic post(input int i, input logic [15:0] a, input logic [1:0] sel, input logic [1:0] ins);
    pend[i]   = 1'b1;
    op_a[i]   = a;
    op_sel[i] = sel;
    op_ins[i] = ins;
  endtask

  initial begin
    int rc;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; op_a[i] = '0; op_sel[i] = '0; op_ins[i] = '0;
    end
    req_bus.req_valid = '0; req_bus.req_A = '0;
    req_bus.req_reg_sel = '0; req_bus.req_instru = '0;
    ula_bus.ula_data = '0; ula_bus.ula_valid_out = 1'b0;
    @(negedge clk_ula);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    rst = 1'b0;
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_stray", stray_cnt, 8'd0);
    check("reset_ula_valid", ula_bus.ula_valid, 1'b0);
    check("reset_rsp_valid", req_bus.rsp_valid, '0);

    // single request, ULA answers 3 cycles after ula_valid
    post(0, 16'h0005, 2'd1, 2'd2);
    next_lat = 3; next_data = 32'h0000_000A;
    grant_log.delete();
    wait_idle(40);
    check("t1_grants", grant_log.size(), 1);
    check("t1_grant0", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    check("t1_data", last_rsp_data, 32'h0000_000A);
    check("t1_err", last_rsp_err, 1'b0);
    check("t1_latency", last_rsp_delta, 4);

    // fairness from reset with all four requesters saturating
    cycle(1'b1, 1'b0);
    for (int i = 0; i < NREQ; i++) post(i, 16'($urandom()), 2'($urandom()), 2'($urandom()));
    req_mask = '1; arrive_pct = 100;
    next_lat = 1; next_data = 32'h0000_1234;
    grant_log.delete();
    for (int k = 0; k < 200 && grant_log.size() < 5; k++) cycle(1'b0, 1'b0);
    req_mask = '0;
    wait_idle(100);
    check("t2_grants", grant_log.size() >= 5, 1'b1);
    for (int k = 0; k < 5; k++)
      check("t2_order", (grant_log.size() > k) ? grant_log[k] : -1, k % NREQ);

    // silent ULA times out, next transaction is normal
    post(2, 16'hBEEF, 2'd3, 2'd1);
    next_lat = SILENT;
    wait_idle(60);
    check("t3_err", last_rsp_err, 1'b1);
    check("t3_data", last_rsp_data, 32'h0);
    check("t3_latency", last_rsp_delta, TIMEOUT + 1);
    post(1, 16'h1111, 2'd0, 2'd3);
    next_lat = 2; next_data = 32'h0000_55AA;
    wait_idle(60);
    check("t3_next_err", last_rsp_err, 1'b0);
    check("t3_next_data", last_rsp_data, 32'h0000_55AA);

    // completion in the ISSUE cycle
    post(3, 16'h00F0, 2'd2, 2'd0);
    next_lat = 0; next_data = 32'hDEAD_BEEF;
    wait_idle(40);
    check("t4_data", last_rsp_data, 32'hDEAD_BEEF);
    check("t4_latency", last_rsp_delta, 1);

    // unsolicited ULA completions while idle
    cycle(1'b1, 1'b0);
    rc = rsp_count;
    run(3, 1'b1);
    run(2, 1'b0);
    check("t5_stray3", stray_cnt, 8'd3);
    check("t5_no_rsp", rsp_count, rc);
    run(300, 1'b1);
    run(1, 1'b0);
    check("t5_stray_sat", stray_cnt, 8'd255);

    // reset in WAIT abandons the transaction and restarts rr from 0
    post(2, 16'h2222, 2'd1, 2'd1);
    next_lat = 1; next_data = 32'h0000_0077;
    wait_idle(40);
    post(3, 16'h3333, 2'd2, 2'd2);
    next_lat = SILENT;
    run(4, 1'b0);
    check("t6_busy_before", busy, 1'b1);
    rc = rsp_count;
    cycle(1'b1, 1'b0);
    rst = 1'b0;
    #1;
    check("t6_busy", busy, 1'b0);
    check("t6_rsp_valid", req_bus.rsp_valid, '0);
    check("t6_ula_A", ula_bus.ula_A, 16'h0);
    check("t6_stray", stray_cnt, 8'd0);
    post(1, 16'h4444, 2'd0, 2'd1);
    post(3, 16'h5555, 2'd3, 2'd3);
    next_lat = 1; next_data = 32'h0000_0099;
    grant_log.delete();
    wait_idle(60);
    check("t6_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 1);
    check("t6_rsp_count", rsp_count, rc + 2);

    // randomized traffic with drops, strays and occasional resets
    req_mask = '1; arrive_pct = 30; drop_pct = 3; rand_lat = 1'b1;
    for (int k = 0; k < 3000; k++)
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 19) == 0);
    req_mask = '0; drop_pct = 0;
    wait_idle(200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
